// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined add/subtract with one carry-chain slice per stage
// Valid/ready handshake; a stalled output freezes every stage.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);
  localparam int SW = WIDTH / STAGES;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic             w_adv;

  assign w_b_eff = sub ? ~B : B;
  assign w_c_eff = sub ? ~Cin : Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_x_in;
    logic [SW-1:0]    w_b_slice;
    logic             w_c_in;
    logic             w_v_in;
    logic             w_sa_in;
    logic             w_sb_in;
    logic [SW:0]      w_sum;

    // r_x carries finished sum slices below slice k and untouched A bits above it
    logic [WIDTH-1:0] r_x;
    logic             r_v;
    logic             r_c;
    logic             r_sa;
    logic             r_sb;

    if (k == 0) begin : g_first
      assign w_x_in    = A;
      assign w_b_slice = w_b_eff[SW-1:0];
      assign w_c_in    = w_c_eff;
      assign w_v_in    = in_valid;
      assign w_sa_in   = A[WIDTH-1];
      assign w_sb_in   = w_b_eff[WIDTH-1];
    end else begin : g_next
      assign w_x_in    = g_stage[k-1].r_x;
      assign w_b_slice = g_stage[k-1].g_y.r_y[SW-1:0];
      assign w_c_in    = g_stage[k-1].r_c;
      assign w_v_in    = g_stage[k-1].r_v;
      assign w_sa_in   = g_stage[k-1].r_sa;
      assign w_sb_in   = g_stage[k-1].r_sb;
    end

    assign w_sum = {1'b0, w_x_in[k*SW +: SW]} + {1'b0, w_b_slice} + {{SW{1'b0}}, w_c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v  <= 1'b0;
        r_x  <= '0;
        r_c  <= 1'b0;
        r_sa <= 1'b0;
        r_sb <= 1'b0;
      end else if (w_adv) begin
        r_v               <= w_v_in;
        r_x               <= w_x_in;
        r_x[k*SW +: SW]   <= w_sum[SW-1:0];
        r_c               <= w_sum[SW];
        r_sa              <= w_sa_in;
        r_sb              <= w_sb_in;
      end
    end

    if (k < STAGES - 1) begin : g_y
      localparam int RW = WIDTH - (k + 1) * SW;
      logic [RW-1:0] r_y;
      logic [RW-1:0] w_y_in;

      if (k == 0) begin : g_yf
        assign w_y_in = w_b_eff[WIDTH-1:SW];
      end else begin : g_yn
        assign w_y_in = g_stage[k-1].g_y.r_y[RW+SW-1:SW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_y <= '0;
        end else if (w_adv) begin
          r_y <= w_y_in;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign S         = g_stage[STAGES-1].r_x;
  assign Cout      = g_stage[STAGES-1].r_c;
  assign Ovf       = (g_stage[STAGES-1].r_sa == g_stage[STAGES-1].r_sb) &&
                     (S[WIDTH-1] != g_stage[STAGES-1].r_sa);

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed self-checking bench for pipelined_adder
// Scoreboard of model results plus hand-computed corner vectors.
module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        Cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] S;
  logic        Cout;
  logic        Ovf;

  int          n_pass   = 0;
  int          n_checks = 0;
  logic [65:0] sb[$];
  logic [65:0] r_exp;
  logic [63:0] va[8];
  logic [63:0] vb[8];

  pipelined_adder #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic c, input logic s);
    logic [63:0] be;
    logic        ce;
    logic [64:0] r;
    logic        ov;
    be = s ? ~b : b;
    ce = s ? ~c : c;
    r  = {1'b0, a} + {1'b0, be} + {64'd0, ce};
    ov = (a[63] == be[63]) && (r[63] != a[63]);
    return {ov, r};
  endfunction

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One cycle: drive at negedge, then settle and score what the next edge will transfer
  task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic c, input logic s, input logic ordy);
    logic [65:0] e;
    @(negedge clk);
    in_valid  = v;
    A         = a;
    B         = b;
    Cin       = c;
    sub       = s;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 67'(out_valid), 67'(0));
      end else begin
        e = sb.pop_front();
        check("result", 67'({Ovf, Cout, S}), 67'(e));
      end
    end
    if (in_valid && in_ready && !rst) sb.push_back(model(a, b, c, s));
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic single(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s, input logic [65:0] exp);
    step(1'b1, a, b, c, s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check({tag, "_early"}, 67'(out_valid), 67'(0));
    end
    idle();
    check({tag, "_valid"}, 67'(out_valid), 67'(1));
    check(tag, 67'({Ovf, Cout, S}), 67'(exp));
    idle();
    check({tag, "_after"}, 67'(out_valid), 67'(0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    A         = '1;
    B         = '1;
    Cin       = 1'b1;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 67'(out_valid), 67'(0));
    check("rst_in_ready", 67'(in_ready), 67'(1));
    check("rst_outputs", 67'({Ovf, Cout, S}), 67'(0));
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle();
      check("rst_priority", 67'(out_valid), 67'(0));
    end

    single("carry_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, {1'b0, 1'b1, 64'd0});
    single("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           {1'b1, 1'b0, 64'h8000_0000_0000_0000});
    single("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    single("sub_noborrow", 64'd7, 64'd5, 1'b1, 1'b1, {1'b0, 1'b1, 64'd1});

    for (int i = 0; i < 100; i++) begin
      step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b1);
      check("b2b_valid", 67'(out_valid), 67'(i >= 4));
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      check("b2b_drain", 67'(out_valid), 67'(1));
    end
    idle();
    check("b2b_empty", 67'(out_valid), 67'(0));

    for (int i = 0; i < 14; i++) begin
      step(1'((i % 2 == 0) && (i < 10)), {$urandom, $urandom}, {$urandom, $urandom},
           1'b0, 1'(i % 3 == 0), 1'b1);
      check("bubble_valid", 67'(out_valid), 67'((i >= 4) && ((i - 4) % 2 == 0) && (i - 4 < 10)));
    end

    for (int i = 0; i < 5; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
    end
    for (int i = 0; i < 4; i++) step(1'b1, va[i], vb[i], 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, va[4], vb[4], 1'b0, 1'b0, 1'b0);
      check("bp_in_ready", 67'(in_ready), 67'(0));
      check("bp_out_valid", 67'(out_valid), 67'(1));
      r_exp = model(va[0], vb[0], 1'b0, 1'b0);
      check("bp_stable", 67'({Ovf, Cout, S}), 67'(r_exp));
    end
    step(1'b1, va[4], vb[4], 1'b0, 1'b0, 1'b1);
    check("bp_release", 67'(in_ready), 67'(1));
    for (int i = 0; i < 4; i++) begin
      idle();
      check("bp_drain", 67'(out_valid), 67'(1));
    end
    idle();
    check("bp_empty", 67'(out_valid), 67'(0));
    check("bp_none_lost", 67'(sb.size()), 67'(0));

    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 64'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      idle();
      check("mid_rst_flush", 67'(out_valid), 67'(0));
    end
    single("post_rst", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
           {1'b0, 1'b0, 64'h1234_5678_9ABC_DF00});

    check("sb_empty", 67'(sb.size()), 67'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
